// File: rtl/alu_cmd_sequencer_pkg.sv
// Shared widths, FSM encoding and command packing for the ALU command sequencer.
package alu_cmd_sequencer_pkg;

  localparam int OPND_W = 4;
  localparam int RES_W  = 5;
  localparam int SEL_W  = 3;
  localparam int CMD_W  = 2 * OPND_W + SEL_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  function automatic logic [CMD_W-1:0] pack_cmd(
    input logic [OPND_W-1:0] a,
    input logic [OPND_W-1:0] b,
    input logic [SEL_W-1:0]  sel
  );
    return {a, b, sel};
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO: power-of-two depth, wrapping pointers, occupancy count.
module alu_cmd_fifo
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = CMD_W
) (
  input  logic                       clock,
  input  logic                       reset_n,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign full      = (r_count == CNT_W'(DEPTH));
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];

  // Storage, pointers and occupancy; simultaneous push and pop leave count as is.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Queues ALU commands, issues them one at a time to an external combinational
// ALU and holds each result until the consumer takes it.
module alu_cmd_sequencer
  import alu_cmd_sequencer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OPND_W-1:0] in_a,
  input  logic [OPND_W-1:0] in_b,
  input  logic [SEL_W-1:0]  in_sel,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [RES_W-1:0]  alu_out,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RES_W-1:0]  out_result,
  output logic [SEL_W-1:0]  out_sel,
  output logic              busy
);

  state_t                   r_state;
  state_t                   w_next;
  logic [OPND_W-1:0]        r_a;
  logic [OPND_W-1:0]        r_b;
  logic [SEL_W-1:0]         r_sel;
  logic [RES_W-1:0]         r_result;
  logic [SEL_W-1:0]         r_out_sel;
  logic                     w_pop;
  logic                     w_capture;
  logic                     w_full;
  logic                     w_empty;
  logic [CMD_W-1:0]         w_fifo_dout;
  logic [$clog2(DEPTH):0]   w_count;

  alu_cmd_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (CMD_W)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (in_valid),
    .pop     (w_pop),
    .din     (pack_cmd(in_a, in_b, in_sel)),
    .dout    (w_fifo_dout),
    .full    (w_full),
    .empty   (w_empty),
    .count   (w_count)
  );

  assign in_ready   = !w_full;
  assign alu_a      = r_a;
  assign alu_b      = r_b;
  assign alu_sel    = r_sel;
  assign out_result = r_result;
  assign out_sel    = r_out_sel;
  assign out_valid  = (r_state == ST_DONE);
  assign busy       = (r_state != ST_IDLE) || (w_count != '0);

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state; a DONE handshake with work queued goes straight back to ISSUE.
  always_comb begin
    w_next    = r_state;
    w_pop     = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_pop  = 1'b1;
          w_next = ST_ISSUE;
        end else begin
          w_next = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        w_capture = 1'b1;
        w_next    = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          if (!w_empty) begin
            w_pop  = 1'b1;
            w_next = ST_ISSUE;
          end else begin
            w_next = ST_IDLE;
          end
        end else begin
          w_next = ST_DONE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Operand registers load only on a pop; result is captured at the end of ISSUE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a       <= '0;
      r_b       <= '0;
      r_sel     <= '0;
      r_result  <= '0;
      r_out_sel <= '0;
    end else begin
      if (w_pop) begin
        {r_a, r_b, r_sel} <= w_fifo_dout;
      end
      if (w_capture) begin
        r_result  <= alu_out;
        r_out_sel <= r_sel;
      end
    end
  end

endmodule
